// File: rtl/i2c_ram_bridge.sv
// i2c_ram_bridge: I2C slave giving an external master burst read/write
// access to a single-port synchronous RAM, with a host-select mux so the
// CPU core owns the RAM port whenever iicing=0.
// Optional build macro: I2C_GLITCH_FILTER_EN adds a 3-sample majority filter
// on sck/sda after the synchronisers (rejects 1-gclk pulses, +2 gclk latency).
module i2c_ram_bridge #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         DATA_W      = 16,
  parameter int         ADDR_W      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              gclk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic              iicing,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              wr_err
);

  localparam int NB = DATA_W / 8;       // bytes per RAM word
  localparam int NI = (ADDR_W + 7) / 8; // index bytes
  localparam int IW = NI * 8;

  typedef enum logic [3:0] {
    S_IDLE, S_DEVADDR, S_DEVACK, S_INDEX, S_IDXACK,
    S_WDATA, S_WACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  // Bus conditioning: synchronisers reset to the idle-high bus level so that
  // leaving reset never manufactures a false edge.
  logic [SYNC_STAGES-1:0] r_sck_sync, r_sda_sync;
  logic                   w_sck, w_sda;
  logic                   r_sck_d, r_sda_d;

  // Shift sck and sda through the synchroniser chains.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] r_sck_flt, r_sda_flt;

  // Keep the last three synchronised samples for the majority vote.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_flt <= '1;
      r_sda_flt <= '1;
    end else begin
      r_sck_flt <= {r_sck_flt[1:0], r_sck_sync[SYNC_STAGES-1]};
      r_sda_flt <= {r_sda_flt[1:0], r_sda_sync[SYNC_STAGES-1]};
    end
  end

  assign w_sck = (r_sck_flt[0] & r_sck_flt[1]) | (r_sck_flt[0] & r_sck_flt[2]) |
                 (r_sck_flt[1] & r_sck_flt[2]);
  assign w_sda = (r_sda_flt[0] & r_sda_flt[1]) | (r_sda_flt[0] & r_sda_flt[2]) |
                 (r_sda_flt[1] & r_sda_flt[2]);
`else
  assign w_sck = r_sck_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
`endif

  // Delayed copies of the conditioned lines for edge detection.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_sck_d <= w_sck;
      r_sda_d <= w_sda;
    end
  end

  logic w_sck_rise, w_sck_fall, w_start, w_stop;
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  // sck must be high on both samples so an sck edge is never taken for START/STOP.
  assign w_start    = r_sda_d & ~w_sda & w_sck & r_sck_d;
  assign w_stop     = ~r_sda_d & w_sda & w_sck & r_sck_d;

  // Protocol state
  state_t            r_state, state_next;
  logic [3:0]        r_bitcnt, bitcnt_next;
  logic [7:0]        r_bytecnt, bytecnt_next;
  logic [7:0]        r_shift, shift_next;
  logic [IW-1:0]     r_idx, idx_next;
  logic [DATA_W-1:0] r_word, word_next;
  logic [DATA_W-1:0] r_tx, tx_next;
  logic [ADDR_W-1:0] r_pointer, pointer_next;
  logic              r_sda_oe, sda_oe_next;
  logic              r_busy, busy_next;
  logic              r_wr_err, wr_err_next;
  logic              r_mem_we, mem_we_next;
  logic              r_ptr_inc, ptr_inc_next;
  logic              r_rw, rw_next;
  // Read pipeline: request (pointer settles) -> issue (address on RAM) -> latch.
  logic              r_rd_req, rd_req_next;
  logic              r_rd_issue, r_rd_latch;
  logic [DATA_W-1:0] r_core_rdata;
  logic              w_rx_state;

  assign w_rx_state = (r_state == S_DEVADDR) || (r_state == S_INDEX) || (r_state == S_WDATA);

  // State and datapath registers.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_bytecnt  <= '0;
      r_shift    <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_tx       <= '0;
      r_pointer  <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_err   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_ptr_inc  <= 1'b0;
      r_rw       <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rd_issue <= 1'b0;
      r_rd_latch <= 1'b0;
    end else begin
      r_state    <= state_next;
      r_bitcnt   <= bitcnt_next;
      r_bytecnt  <= bytecnt_next;
      r_shift    <= shift_next;
      r_idx      <= idx_next;
      r_word     <= word_next;
      r_tx       <= tx_next;
      r_pointer  <= pointer_next;
      r_sda_oe   <= sda_oe_next;
      r_busy     <= busy_next;
      r_wr_err   <= wr_err_next;
      r_mem_we   <= mem_we_next;
      r_ptr_inc  <= ptr_inc_next;
      r_rw       <= rw_next;
      r_rd_req   <= rd_req_next;
      r_rd_issue <= r_rd_req;
      r_rd_latch <= r_rd_issue;
    end
  end

  // Next-state and datapath logic; START/STOP override every bit event.
  always_comb begin
    state_next   = r_state;
    bitcnt_next  = r_bitcnt;
    bytecnt_next = r_bytecnt;
    shift_next   = r_shift;
    idx_next     = r_idx;
    word_next    = r_word;
    tx_next      = r_tx;
    pointer_next = r_pointer;
    sda_oe_next  = r_sda_oe;
    busy_next    = r_busy;
    wr_err_next  = r_wr_err;
    rw_next      = r_rw;
    mem_we_next  = 1'b0;
    ptr_inc_next = 1'b0;
    rd_req_next  = 1'b0;

    if (r_ptr_inc) pointer_next = r_pointer + ADDR_W'(1);
    if (r_rd_latch) tx_next = mem_rdata;

    if (w_start) begin
      state_next   = S_DEVADDR;
      bitcnt_next  = '0;
      bytecnt_next = '0;
      sda_oe_next  = 1'b0;
    end else if (w_stop) begin
      state_next   = S_IDLE;
      bitcnt_next  = '0;
      bytecnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else begin
      if (w_rx_state && w_sck_rise && r_bitcnt != 4'd8) begin
        shift_next  = {r_shift[6:0], w_sda};
        bitcnt_next = r_bitcnt + 4'd1;
      end
      case (r_state)
        S_DEVADDR: begin
          if (w_sck_fall && r_bitcnt == 4'd8) begin
            bitcnt_next = '0;
            if (r_shift[7:1] == DEV_ADDR) begin
              state_next  = S_DEVACK;
              sda_oe_next = 1'b1;
              busy_next   = 1'b1;
              rw_next     = r_shift[0];
              rd_req_next = r_shift[0];
            end else begin
              state_next = S_IGNORE;
              busy_next  = 1'b0;
            end
          end
        end
        S_DEVACK: begin
          if (w_sck_fall) begin
            bytecnt_next = '0;
            bitcnt_next  = '0;
            if (r_rw) begin
              state_next  = S_RDATA;
              sda_oe_next = ~r_tx[DATA_W-1];
            end else begin
              state_next  = S_INDEX;
              sda_oe_next = 1'b0;
            end
          end
        end
        S_INDEX: begin
          if (w_sck_fall && r_bitcnt == 4'd8) begin
            bitcnt_next = '0;
            state_next  = S_IDXACK;
            sda_oe_next = 1'b1;
            idx_next    = (r_idx << 8) | IW'(r_shift);
          end
        end
        S_IDXACK: begin
          if (w_sck_fall) begin
            sda_oe_next = 1'b0;
            if (r_bytecnt == 8'(NI - 1)) begin
              pointer_next = r_idx[ADDR_W-1:0];
              bytecnt_next = '0;
              state_next   = S_WDATA;
            end else begin
              bytecnt_next = r_bytecnt + 8'd1;
              state_next   = S_INDEX;
            end
          end
        end
        S_WDATA: begin
          if (w_sck_fall && r_bitcnt == 4'd8) begin
            bitcnt_next = '0;
            state_next  = S_WACK;
            sda_oe_next = 1'b1;
            word_next   = (r_word << 8) | DATA_W'(r_shift);
          end
        end
        S_WACK: begin
          if (w_sck_fall) begin
            sda_oe_next = 1'b0;
            state_next  = S_WDATA;
            if (r_bytecnt == 8'(NB - 1)) begin
              bytecnt_next = '0;
              ptr_inc_next = 1'b1;
              if (iicing) mem_we_next = 1'b1;
              else        wr_err_next = 1'b1;
            end else begin
              bytecnt_next = r_bytecnt + 8'd1;
            end
          end
        end
        S_RDATA: begin
          if (w_sck_rise && r_bitcnt != 4'd8) begin
            tx_next     = r_tx << 1;
            bitcnt_next = r_bitcnt + 4'd1;
          end else if (w_sck_fall) begin
            if (r_bitcnt == 4'd8) begin
              sda_oe_next = 1'b0;
              bitcnt_next = '0;
              state_next  = S_RACK;
            end else begin
              sda_oe_next = ~r_tx[DATA_W-1];
            end
          end
        end
        S_RACK: begin
          if (w_sck_rise) begin
            if (w_sda) begin
              state_next = S_IGNORE;
            end else if (r_bytecnt == 8'(NB - 1)) begin
              bytecnt_next = '0;
              ptr_inc_next = 1'b1;
              rd_req_next  = 1'b1;
            end else begin
              bytecnt_next = r_bytecnt + 8'd1;
            end
          end else if (w_sck_fall) begin
            state_next  = S_RDATA;
            sda_oe_next = ~r_tx[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

  // Core read data follows the RAM only while the core owns the port.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n)       r_core_rdata <= '0;
    else if (!iicing) r_core_rdata <= mem_rdata;
  end

  assign mem_we     = iicing ? r_mem_we  : core_we;
  assign mem_addr   = iicing ? r_pointer : core_addr;
  assign mem_wdata  = iicing ? r_word    : core_wdata;
  assign core_rdata = r_core_rdata;
  assign sda_oe     = r_sda_oe;
  assign busy       = r_busy;
  assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_i2c_ram_bridge.sv
// Self-checking bench for i2c_ram_bridge: bit-banged I2C master, behavioural
// RAM, reference memory model and scoreboards for RAM writes and read bytes.
module tb_i2c_ram_bridge;
  localparam time Q = 80ns;  // quarter of an sck period (8 gclk)

  logic        gclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_i;
  logic        sda_oe;
  logic        iicing = 1'b1;
  logic        core_we = 1'b0;
  logic [7:0]  core_addr = 8'h00;
  logic [15:0] core_wdata = 16'h0000;
  logic [15:0] core_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        busy;
  logic        wr_err;

  assign sda_i = sda_m & ~sda_oe;  // open-drain wired-AND

  i2c_ram_bridge dut (
    .gclk(gclk), .rst_n(rst_n), .sck(sck), .sda_i(sda_i), .sda_oe(sda_oe),
    .iicing(iicing), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .wr_err(wr_err)
  );

  always #5ns gclk = ~gclk;

  // Behavioural single-port RAM with 1-cycle read latency.
  logic [15:0] ram [256];
  always @(posedge gclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model and scoreboards.
  typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
  logic [15:0] model_mem [256];
  int          model_ptr = 0;
  wr_t         exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  got_rd_q[$];
  logic [15:0] wq[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Write monitor: every bridge-driven RAM write must match the next expected one.
  always @(negedge gclk) begin
    if (rst_n && iicing && mem_we) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_mem_we", {8'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check("mem_write", {8'h0, mem_addr, mem_wdata}, {8'h0, e.a, e.d});
      end
    end
  end

  // Read monitor: pair each byte received on the bus with its expectation.
  always @(negedge gclk) begin
    while (got_rd_q.size() > 0) begin
      logic [7:0] g;
      g = got_rd_q.pop_front();
      if (exp_rd_q.size() == 0) check("unexpected_rd_byte", {24'h0, g}, 32'hFFFF_FFFF);
      else check("rd_byte", {24'h0, g}, {24'h0, exp_rd_q.pop_front()});
    end
  end

  // ---------------- bus-level master primitives ----------------
  task automatic bus_start();  // also a repeated START when sck is low
    sda_m = 1'b1; #Q; sck = 1'b1; #Q; sda_m = 1'b0; #Q; sck = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; sck = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q; sck = 1'b1; #(2*Q); sck = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q; sck = 1'b1; #Q; ack = ~sda_i; #Q; sck = 1'b0; #Q;
  endtask

  task automatic read_byte(input bit nack);
    logic [7:0] b;
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; sck = 1'b1; #Q; b[i] = sda_i; #Q; sck = 1'b0; #Q;
    end
    got_rd_q.push_back(b);
    sda_m = nack; #Q; sck = 1'b1; #(2*Q); sck = 1'b0; #Q;
    sda_m = 1'b1;
  endtask

  // ---------------- transaction-level helpers ----------------
  // Write the words in wq starting at idx.
  task automatic do_write(input logic [7:0] idx);
    bit ack;
    bus_start();
    write_byte(8'hA0, ack); check("ack_wdev", ack, 1);
    check("busy_addressed", busy, 1);
    write_byte(idx, ack);   check("ack_idx", ack, 1);
    model_ptr = idx;
    foreach (wq[k]) begin
      write_byte(wq[k][15:8], ack); check("ack_wdata_hi", ack, 1);
      if (iicing) begin
        exp_wr_q.push_back('{a: model_ptr[7:0], d: wq[k]});
        model_mem[model_ptr] = wq[k];
      end
      write_byte(wq[k][7:0], ack); check("ack_wdata_lo", ack, 1);
      model_ptr = (model_ptr + 1) % 256;
    end
    bus_stop();
    check("busy_after_stop", busy, 0);
  endtask

  // Read nwords, optionally after loading idx with a combined-format write.
  task automatic do_read(input bit use_idx, input logic [7:0] idx, input int nwords);
    bit ack;
    logic [15:0] wv;
    bus_start();
    if (use_idx) begin
      write_byte(8'hA0, ack); check("ack_wdev", ack, 1);
      write_byte(idx, ack);   check("ack_idx", ack, 1);
      model_ptr = idx;
      bus_start();
    end
    write_byte(8'hA1, ack); check("ack_rdev", ack, 1);
    for (int w = 0; w < nwords; w++) begin
      wv = model_mem[model_ptr];
      exp_rd_q.push_back(wv[15:8]);
      read_byte(1'b0);
      exp_rd_q.push_back(wv[7:0]);
      read_byte(w == nwords - 1);
      if (w != nwords - 1) model_ptr = (model_ptr + 1) % 256;
    end
    check("sda_released_after_nack", sda_oe, 0);
    bus_stop();
    check("busy_after_stop", busy, 0);
  endtask

  initial begin
    #1.5ms;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ack;
    logic [7:0] idx;
    int n;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'h0;
      model_mem[i] = 16'h0;
    end

    // Reset state
    #23ns;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_core_rdata", core_rdata, 0);
    rst_n = 1'b1;
    #(4*Q);

    // Write burst, then combined read of the same words
    wq = '{16'h1234, 16'h5678};
    do_write(8'h10);
    do_read(1'b1, 8'h10, 2);

    // Index wrap from 0xFF to 0x00
    wq = '{16'hCAFE, 16'hF00D};
    do_write(8'hFF);
    do_read(1'b1, 8'hFF, 2);

    // Wrong device address is ignored until STOP
    bus_start();
    write_byte(8'hA4, ack); check("nack_wrong_addr", ack, 0);
    check("busy_wrong_addr", busy, 0);
    write_byte(8'h10, ack); check("ignore_no_ack", ack, 0);
    bus_stop();

    // Write burst while the core owns the RAM port
    iicing = 1'b0;
    wq = '{16'hDEAD, 16'hBEEF};
    do_write(8'h40);
    check("wr_err_set", wr_err, 1);
    @(negedge gclk);
    core_addr = 8'h33; core_wdata = 16'hA55A; core_we = 1'b1;
    #1;
    check("pass_we", mem_we, 1);
    check("pass_addr", mem_addr, 8'h33);
    check("pass_wdata", mem_wdata, 16'hA55A);
    @(negedge gclk);
    core_we = 1'b0;
    model_mem[8'h33] = 16'hA55A;
    @(negedge gclk); @(negedge gclk);
    check("core_rdata", core_rdata, 16'hA55A);
    iicing = 1'b1;
    core_addr = 8'h00;
    @(negedge gclk); @(negedge gclk); @(negedge gclk);
    check("core_rdata_hold", core_rdata, 16'hA55A);
    do_read(1'b1, 8'h40, 2);
    do_read(1'b1, 8'h33, 1);

    // Randomised write/read-back bursts
    for (int t = 0; t < 4; t++) begin
      idx = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
      do_write(idx);
      do_read(1'b1, idx, $urandom_range(1, n));
    end

    // STOP after one of two data bytes discards the partial word
    bus_start();
    write_byte(8'hA0, ack); check("ack_wdev", ack, 1);
    write_byte(8'h20, ack); check("ack_idx", ack, 1);
    write_byte(8'hAA, ack); check("ack_partial", ack, 1);
    bus_stop();
    check("busy_partial_stop", busy, 0);

    // Reset pulsed mid-byte
    bus_start();
    write_byte(8'hA0, ack); check("ack_wdev", ack, 1);
    write_byte(8'h21, ack); check("ack_idx", ack, 1);
    for (int i = 0; i < 4; i++) begin
      sda_m = i[0]; #Q; sck = 1'b1; #(2*Q); sck = 1'b0; #Q;
    end
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst2_sda_oe", sda_oe, 0);
    check("rst2_busy", busy, 0);
    check("rst2_wr_err", wr_err, 0);
    check("rst2_mem_we", mem_we, 0);
    check("rst2_core_rdata", core_rdata, 0);
    sck = 1'b1; sda_m = 1'b1;
    #(2*Q);
    rst_n = 1'b1;
    model_ptr = 0;
    #(4*Q);
    do_read(1'b0, 8'h00, 1);   // pointer restarts at 0 after reset
    do_read(1'b1, 8'h20, 2);   // partial writes left 0x20/0x21 untouched

    #(4*Q);
    check("wr_scoreboard_drained", exp_wr_q.size(), 0);
    check("rd_scoreboard_drained", exp_rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
